// File: rtl/window_gen_if.sv
// window_gen_if: valid/ready bundle carrying raster pixels in and KxK windows out.
interface window_gen_if #(
  parameter int K = 5, IMG_W = 516, IMG_H = 516, PIX_W = 8, OUT_W = 10
);
  logic                     in_valid;
  logic                     in_ready;
  logic [PIX_W-1:0]         in_pixel;
  logic                     out_valid;
  logic                     out_ready;
  logic [K*K*OUT_W-1:0]     out_window;
  logic [$clog2(IMG_H)-1:0] out_row;
  logic [$clog2(IMG_W)-1:0] out_col;
  logic                     out_last;
  modport master(output in_valid, in_pixel, out_ready,
                 input  in_ready, out_valid, out_window, out_row, out_col, out_last);
  modport slave (input  in_valid, in_pixel, out_ready,
                 output in_ready, out_valid, out_window, out_row, out_col, out_last);
endinterface

// File: rtl/window_gen.sv
// window_gen: raster pixel stream to KxK sliding windows using K-1 line buffers.
module window_gen #(
  parameter int K = 5, IMG_W = 516, IMG_H = 516, PIX_W = 8, OUT_W = 10
) (
  input logic        clk,
  input logic        rst,
  window_gen_if.slave bus
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  typedef enum logic {FILL, STREAM} state_t;
  state_t               r_state, w_state_nxt;
  logic [RW-1:0]        r_row;
  logic [CW-1:0]        r_col;
  logic [PIX_W-1:0]     r_lb [K-1][IMG_W];
  logic [PIX_W-1:0]     r_win [K][K];
  logic [PIX_W-1:0]     w_colv [K];
  logic [PIX_W-1:0]     w_win_nxt [K][K];
  logic [K*K*OUT_W-1:0] w_out_nxt;
  logic                 w_accept, w_col_end, w_row_end, w_emit;
  logic                 r_out_valid, r_out_last;
  logic [RW-1:0]        r_out_row;
  logic [CW-1:0]        r_out_col;
  logic [K*K*OUT_W-1:0] r_out_window;

  assign bus.in_ready   = !r_out_valid || bus.out_ready;
  assign w_accept       = bus.in_valid && bus.in_ready;
  assign w_col_end      = r_col == CW'(IMG_W-1);
  assign w_row_end      = r_row == RW'(IMG_H-1);
  assign bus.out_valid  = r_out_valid;
  assign bus.out_last   = r_out_last;
  assign bus.out_row    = r_out_row;
  assign bus.out_col    = r_out_col;
  assign bus.out_window = r_out_window;

  always_ff @(posedge clk)
    if (!rst) r_state <= FILL;
    else r_state <= w_state_nxt;

  always_comb
    w_state_nxt = !w_accept ? r_state :
                  (r_state == FILL) ? ((r_row == RW'(K-1)) ? STREAM : FILL) :
                  ((w_row_end && w_col_end) ? FILL : STREAM);

  always_comb
    w_emit = w_accept && r_state == STREAM && r_col >= CW'(K-1);

  // Column entering the window: oldest buffered row on top, live pixel at the bottom.
  always_comb begin
    for (int j = 0; j < K-1; j++) w_colv[j] = r_lb[j][r_col];
    w_colv[K-1] = bus.in_pixel;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K-1; c++) w_win_nxt[r][c] = r_win[r][c+1];
      w_win_nxt[r][K-1] = w_colv[r];
    end
  end

  always_comb begin
    w_out_nxt = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w_out_nxt[(r*K+c)*OUT_W +: OUT_W] = OUT_W'(w_win_nxt[r][c]);
  end

  always_ff @(posedge clk)
    if (w_accept) begin
      for (int j = 0; j < K-2; j++) r_lb[j][r_col] <= r_lb[j+1][r_col];
      r_lb[K-2][r_col] <= bus.in_pixel;
      r_win <= w_win_nxt;
    end

  always_ff @(posedge clk)
    if (!rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      r_col <= w_col_end ? '0 : r_col + 1'b1;
      if (w_col_end) r_row <= w_row_end ? '0 : r_row + 1'b1;
    end

  always_ff @(posedge clk)
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_out_window <= '0;
    end else if (w_emit) begin
      r_out_valid  <= 1'b1;
      r_out_last   <= w_row_end && w_col_end;
      r_out_row    <= r_row - RW'(K-1);
      r_out_col    <= r_col - CW'(K-1);
      r_out_window <= w_out_nxt;
    end else if (bus.out_ready) r_out_valid <= 1'b0;
endmodule

// File: doc/window_gen.md
# window_gen

Parametrised sliding-window generator that converts a raster pixel stream into K×K convolution windows for `conv_unit`. It generalises the fixed 5×5 window fetch over the 516-wide padded image to any odd kernel size, image size and pixel width. Row storage is K−1 on-chip line buffers, and both input and output use valid/ready handshakes. The block sits between the pixel source (image memory reader or camera interface) and the Gabor filter bank.

## Interface

Parameters:

- `K`, default 5: window size. Odd, 3..13.
- `IMG_W`, default 516: frame width in pixels, including padding. Must be ≥ K.
- `IMG_H`, default 516: frame height in rows, including padding. Must be ≥ K.
- `PIX_W`, default 8: input pixel width.
- `OUT_W`, default 10: output tap width. Each tap is the input pixel zero-extended to this width (OUT_W ≥ PIX_W).

Ports:

- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `in_valid`  in  1: `in_pixel` is valid.
- `in_ready`  out  1: block can accept a pixel this cycle.
- `in_pixel`  in  PIX_W: raster-order pixel.
- `out_valid`  out  1: window output is valid.
- `out_ready`  in  1: consumer accepts the window.
- `out_window`  out  K*K*OUT_W: taps. Tap (r,c) is at `[(r*K+c)*OUT_W +: OUT_W]`. Tap 0 is the top-left pixel.
- `out_row`  out  $clog2(IMG_H): top-left row of the window.
- `out_col`  out  $clog2(IMG_W): top-left column of the window.
- `out_last`  out  1: asserted with the final window of the frame.

## Operation

- **Transfer rules:** an input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- **Counters:** `col` counts 0..IMG_W−1 and `row` counts 0..IMG_H−1, both tracking the pixel being accepted.
  - `col` wraps to 0 after IMG_W−1, and `row` increments at that point.
  - After pixel (IMG_H−1, IMG_W−1), both wrap to 0. The next frame starts with no idle cycle.
- **Line buffers:** K−1 buffers of IMG_W entries, each PIX_W wide, addressed by `col`.
  - On each accepted pixel, the column (K−1 buffered pixels from rows row−K+1..row−1, plus `in_pixel`) shifts into the right end of a K×K shift register.
  - The buffers are updated in the same cycle.
  - Buffer contents have no reset value.
- **Phases:**
  - FILL: row < K−1. No windows are emitted.
  - STREAM: row ≥ K−1. A window is emitted on acceptance of every pixel with col ≥ K−1.
  - FILL → STREAM on the first accepted pixel of row K−1. STREAM → FILL on wrap after the last frame pixel.
- **Emitted window:**
  - Registered into the output stage with `out_row = row−K+1`, `out_col = col−K+1`.
  - `out_last = (row == IMG_H−1 && col == IMG_W−1)`.
- **Window count:** (IMG_W−K+1)×(IMG_H−K+1) windows per frame. With the defaults this is 262144.
- **No padding:** the block adds no border padding. Padding is the source's responsibility.
- **Backpressure:**
  - `in_ready = !out_valid || out_ready`.
  - The output register holds `out_window`, `out_row`, `out_col` and `out_last` stable while `out_valid && !out_ready`.
- **Simultaneous output and input transfer:** when an output transfer and an input transfer producing a new window occur in the same cycle, the output reloads and `out_valid` stays 1.
- **Output transfer only:** `out_valid` falls when an output transfer occurs with no new window.
- **Reset:**
  - Reset mid-frame clears `row`, `col`, `out_valid`, `out_last`, `out_row`, `out_col` and `out_window` to 0, and the phase returns to FILL.
  - The partial frame is discarded. The next accepted pixel is treated as (0,0).

## Timing

- **Reset values:** `out_valid` = 0, `out_last` = 0, `out_row` = 0, `out_col` = 0, `out_window` = 0. `in_ready` is 1 in the cycle after reset releases.
- **Latency:** `out_valid` rises one cycle after the clock edge that accepts the bottom-right pixel of the window.
- **Throughput:** one pixel per clock, and one window per clock in STREAM when `out_ready` is held high.
- **No combinational path** from `in_valid` or `in_pixel` to any output. `in_ready` depends combinationally only on `out_ready` and `out_valid`.
- **Input stalls:** `in_valid` low stalls all state. Counters and buffers do not advance.

## Test plan

All scenarios use K=3, IMG_W=6, IMG_H=5, PIX_W=8, and drive pixel value row*6+col.

- **Continuous stream, out_ready=1.** The first `out_valid` comes one cycle after accepting pixel 14. It carries window {0,1,2,6,7,8,12,13,14}, row 0, col 0.
  - Exactly 12 windows are produced.
  - The last window is {15,16,17,21,22,23,27,28,29}, row 2, col 3, `out_last`=1.
- **No emission outside STREAM.**
  - No `out_valid` during rows 0–1.
  - No `out_valid` following pixels at col 0–1 of rows 2–4 (e.g. after 18 and 19).
- **Backpressure.** Drop `out_ready` for 4 cycles while the window at (1,2) is valid.
  - The window holds {8,9,10,14,15,16,20,21,22}.
  - `in_ready`=0 for those cycles.
  - No pixel is lost. The next window is (1,3).
- **Random in_valid and out_ready gaps (50%) over 3 back-to-back frames.** 36 windows are produced, all matching the model.
  - `out_last` pulses exactly 3 times.
  - Frame 2 starts at (0,0) without a gap.
- **Reset mid-frame.** Assert `rst`=0 for 1 cycle after pixel 20 is accepted.
  - All outputs read 0.
  - A fresh frame then yields a first window equal to {0,1,2,6,7,8,12,13,14}.
- **Default parameters (K=5, 516×516) on a ramp image.**
  - 262144 windows are produced.
  - Tap 0 of the window at (r,c) equals pixel (r,c), and tap 24 equals pixel (r+4,c+4).
